// File: rtl/i2c_oled_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_oled_slave
//  Description : I2C target modelling an SSD1306-style OLED controller.
//                Oversamples SCL/SDA, detects START/STOP, ACKs its address,
//                parses control bytes (Co, D/C#) and strobes out each
//                command/data byte. Reads are answered with status_byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_oled_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] status_byte,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_CTRL   = 3'd2,
    S_BYTE   = 3'd3,
    S_RD     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]  r_bit_cnt;   // 0..7 data bits, 8 = waiting for ACK clock, 9 = in ACK clock
  logic [6:0]  r_sr;
  logic        r_rw, r_co, r_dc;
  logic        r_sda_oe;
  logic [7:0]  r_rx_byte;
  logic        r_rx_is_data, r_rx_valid;
  logic        w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic        w_start, w_stop;
  logic [7:0]  w_shift;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  // SCL must be stable high on both sides of the SDA edge for a bus condition
  assign w_start    = w_sda_fall & r_scl_s2 & r_scl_d;
  assign w_stop     = w_sda_rise & r_scl_s2 & r_scl_d;
  assign w_shift    = {r_sr, r_sda_s2};

  assign sda_oe     = r_sda_oe;
  assign rx_byte    = r_rx_byte;
  assign rx_is_data = r_rx_is_data;
  assign rx_valid   = r_rx_valid;
  // Once the address matched (ADDR only reaches its ACK slot on a match) we are busy
  assign busy = (r_state == S_CTRL) || (r_state == S_BYTE) || (r_state == S_RD) ||
                ((r_state == S_ADDR) && (r_bit_cnt >= 4'd8));

  // Two-flop synchronisers plus one delay stage for edge detection; idle bus is high
  always_ff @(posedge CLK) begin
    if (RST) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: bus conditions override everything, otherwise advance at byte ends
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = S_ADDR;
    end else if (w_stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise && (r_bit_cnt == 4'd7) && (w_shift[7:1] != SLAVE_ADDR))
            w_next = S_IGNORE;
          else if (w_scl_fall && (r_bit_cnt == 4'd9))
            w_next = r_rw ? S_RD : S_CTRL;
        end
        S_CTRL: if (w_scl_fall && (r_bit_cnt == 4'd9)) w_next = S_BYTE;
        S_BYTE: if (w_scl_fall && (r_bit_cnt == 4'd9)) w_next = r_co ? S_CTRL : S_BYTE;
        // Master NACK (SDA high) on the 9th rise ends the read
        S_RD:   if (w_scl_rise && (r_bit_cnt == 4'd8) && r_sda_s2) w_next = S_IGNORE;
        default: w_next = r_state;
      endcase
    end
  end

  // Bit counter, shift register, ACK/read drive and received-byte strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_cnt    <= 4'd0;
      r_sr         <= 7'd0;
      r_rw         <= 1'b0;
      r_co         <= 1'b0;
      r_dc         <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_byte    <= 8'h00;
      r_rx_is_data <= 1'b0;
      r_rx_valid   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_CTRL, S_BYTE: begin
            if (w_scl_rise) begin
              if (r_bit_cnt < 4'd8) begin
                r_sr      <= w_shift[6:0];
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd7) begin
                  if (r_state == S_ADDR) r_rw <= r_sda_s2;
                  if (r_state == S_CTRL) begin
                    r_co <= w_shift[7];
                    r_dc <= w_shift[6];
                  end
                  if (r_state == S_BYTE) begin
                    r_rx_byte    <= w_shift;
                    r_rx_is_data <= r_dc;
                    r_rx_valid   <= 1'b1;
                  end
                end
              end else if (r_bit_cnt == 4'd8) begin
                r_bit_cnt <= 4'd9;
              end
            end
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b1;                 // ACK slot
              end else if (r_bit_cnt == 4'd9) begin
                r_bit_cnt <= 4'd0;
                if ((r_state == S_ADDR) && r_rw) begin
                  // Entering a read: first status bit goes out right away
                  r_sr     <= status_byte[6:0];
                  r_sda_oe <= ~status_byte[7];
                end else begin
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          S_RD: begin
            if (w_scl_rise && (r_bit_cnt < 4'd9)) r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;                 // release for master ACK
              end else if (r_bit_cnt == 4'd9) begin
                r_sr      <= status_byte[6:0];
                r_sda_oe  <= ~status_byte[7];
                r_bit_cnt <= 4'd0;
              end else if (r_bit_cnt != 4'd0) begin
                r_sda_oe <= ~r_sr[6];
                r_sr     <= {r_sr[5:0], 1'b0};
              end
            end
          end
          default: begin
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_oled_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_oled_slave
//  Description : Self-checking bench for i2c_oled_slave: table of directed
//                transactions, hand-written corner sequences and randomized
//                traffic checked against a byte-level protocol model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_oled_slave;

  localparam int Q = 5;
  localparam int H = 10;

  logic       CLK = 1'b0;
  logic       RST;
  logic       tb_scl, tb_sda;
  logic [7:0] status_byte;
  logic       sda_oe, rx_is_data, rx_valid, busy;
  logic [7:0] rx_byte;
  logic       w_sda_bus;

  // Open-drain bus: either side can pull low
  assign w_sda_bus = tb_sda & ~sda_oe;

  always #5 CLK = ~CLK;

  i2c_oled_slave #(.SLAVE_ADDR(7'h3C)) dut (
    .CLK(CLK), .RST(RST), .scl_in(tb_scl), .sda_in(w_sda_bus), .sda_oe(sda_oe),
    .status_byte(status_byte), .rx_byte(rx_byte), .rx_is_data(rx_is_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Strobe capture and pulse-width / drive monitors
  logic [8:0] rxq[$];
  int         long_pulse = 0;
  int         oe_seen    = 0;
  logic       prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (rx_valid) rxq.push_back({rx_is_data, rx_byte});
    if (rx_valid && prev_valid) long_pulse++;
    prev_valid = rx_valid;
    if (sda_oe) oe_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_start();
    wt(Q); tb_sda = 1'b1; wt(Q); tb_scl = 1'b1; wt(H); tb_sda = 1'b0; wt(H); tb_scl = 1'b0;
  endtask

  task automatic bus_stop();
    wt(Q); tb_sda = 1'b0; wt(Q); tb_scl = 1'b1; wt(H); tb_sda = 1'b1; wt(H);
  endtask

  task automatic send_bit(input logic b);
    wt(Q); tb_sda = b; wt(Q); tb_scl = 1'b1; wt(H); tb_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wt(Q); tb_sda = 1'b1; wt(Q); tb_scl = 1'b1; wt(H / 2);
    ack = ~w_sda_bus;
    wt(H / 2); tb_scl = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    for (int i = 7; i >= 0; i--) begin
      wt(Q); tb_sda = 1'b1; wt(Q); tb_scl = 1'b1; wt(H / 2);
      d[i] = w_sda_bus;
      wt(H / 2); tb_scl = 1'b0;
    end
    wt(Q); tb_sda = ~master_ack; wt(Q); tb_scl = 1'b1; wt(H); tb_scl = 1'b0;
    wt(Q); tb_sda = 1'b1;
  endtask

  // Payload following the address byte and the strobes it should produce
  logic [7:0] pay[$];
  logic [8:0] exp_q[$];

  // Protocol model: first payload byte is control; Co=1 means exactly one byte
  // follows before the next control byte, Co=0 means the rest are all data.
  task automatic model_write(input logic [7:0] addr, output logic acked);
    logic need_ctrl, co, dc;
    exp_q.delete();
    acked = (addr[7:1] == 7'h3C) && !addr[0];
    if (!acked) return;
    need_ctrl = 1'b1; co = 1'b0; dc = 1'b0;
    foreach (pay[i]) begin
      if (need_ctrl) begin
        co = pay[i][7]; dc = pay[i][6]; need_ctrl = 1'b0;
      end else begin
        exp_q.push_back({dc, pay[i]});
        if (co) need_ctrl = 1'b1;
      end
    end
  endtask

  task automatic run_write(input logic [7:0] addr, input logic exp_ack);
    int   base, oe0;
    logic ack;
    base = rxq.size();
    oe0  = oe_seen;
    bus_start();
    write_byte(addr, ack);
    check("addr_ack", {31'd0, ack}, {31'd0, exp_ack});
    if (exp_ack) begin
      check("busy_mid", {31'd0, busy}, 32'd1);
      foreach (pay[i]) begin
        write_byte(pay[i], ack);
        check("byte_ack", {31'd0, ack}, 32'd1);
      end
    end else begin
      check("busy_nak", {31'd0, busy}, 32'd0);
      check("oe_nak", oe_seen - oe0, 32'd0);
    end
    bus_stop();
    wt(4);
    check("busy_stop", {31'd0, busy}, 32'd0);
    check("oe_stop", {31'd0, sda_oe}, 32'd0);
    check("strobe_cnt", rxq.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < rxq.size()) check("strobe", {23'd0, rxq[base + i]}, {23'd0, exp_q[i]});
  endtask

  task automatic run_read(input logic [7:0] st, input int n);
    int         base;
    logic       ack;
    logic [7:0] d;
    base = rxq.size();
    status_byte = st;
    bus_start();
    write_byte(8'h79, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i < n - 1);
      check("rd_byte", {24'd0, d}, {24'd0, st});
    end
    wt(4);
    check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    bus_stop();
    wt(4);
    check("rd_busy_stop", {31'd0, busy}, 32'd0);
    check("rd_no_strobe", rxq.size() - base, 32'd0);
  endtask

  typedef struct {
    logic [7:0]      addr;
    logic            ack;
    int              n;
    logic [3:0][7:0] pay;
    int              nexp;
    logic [1:0][8:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, acked;
    logic [7:0] a;
    int         b0;

    // pay[0] is the first byte sent, exp[0] the first strobe
    vt[0] = '{8'h78, 1'b1, 3, 32'h00AF_AE00, 2, {9'h0AF, 9'h0AE}};
    vt[1] = '{8'h78, 1'b1, 4, 32'h55C0_8D80, 2, {9'h155, 9'h08D}};
    vt[2] = '{8'h7A, 1'b0, 0, 32'h0,         0, 18'h0};
    vt[3] = '{8'h78, 1'b1, 3, 32'h0022_1140, 2, {9'h122, 9'h111}};

    RST = 1'b1; tb_scl = 1'b1; tb_sda = 1'b1; status_byte = 8'h00;
    wt(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_rx_is_data", {31'd0, rx_is_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    wt(5);

    // Directed write table
    for (int k = 0; k < 4; k++) begin
      pay.delete();
      exp_q.delete();
      for (int j = 0; j < vt[k].n; j++) pay.push_back(vt[k].pay[j]);
      for (int j = 0; j < vt[k].nexp; j++) exp_q.push_back(vt[k].exp[j]);
      run_write(vt[k].addr, vt[k].ack);
    end

    // Read: ACK first byte, NACK second
    run_read(8'hA5, 2);

    // Repeated START cuts a data byte after 4 bits
    b0 = rxq.size();
    bus_start();
    write_byte(8'h78, ack);
    check("t5_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h40, ack);
    check("t5_ctrl_ack", {31'd0, ack}, 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    pay.delete(); pay.push_back(8'h40); pay.push_back(8'h12);
    exp_q.delete(); exp_q.push_back(9'h112);
    run_write(8'h78, 1'b1);
    check("t5_total_strobes", rxq.size() - b0, 32'd1);

    // Reset while the slave is driving an ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a_bit(i));
    for (int i = 0; i < 40 && !sda_oe; i++) wt(1);
    check("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
    RST = 1'b1;
    wt(1);
    check("t6_oe_after_rst", {31'd0, sda_oe}, 32'd0);
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    tb_sda = 1'b1;
    wt(4);
    pay.delete(); pay.push_back(8'h00); pay.push_back(8'h3C);
    exp_q.delete(); exp_q.push_back(9'h03C);
    run_write(8'h78, 1'b1);

    // Randomized traffic against the protocol model
    for (int t = 0; t < 16; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        run_read(8'($urandom), $urandom_range(1, 3));
      end else begin
        a = (r == 2) ? {7'($urandom), 1'b0} : 8'h78;
        pay.delete();
        for (int j = 0; j < $urandom_range(1, 6); j++) pay.push_back(8'($urandom));
        model_write(a, acked);
        run_write(a, acked);
      end
    end

    check("rx_valid_width", long_pulse, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bits of the 0x78 address used in the reset-during-ACK sequence
  function automatic logic a_bit(input int i);
    logic [7:0] v;
    v = 8'h78;
    return v[i];
  endfunction

endmodule
`default_nettype wire
